// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light sequencer slice.
//   phase_t        : signal-head phase encoding
//   LAMP_R/Y/G     : one-hot {R,Y,G} lamp codes
//   CNT_W_DEFAULT  : default cycle-counter width
package traffic_pkg;

  localparam int unsigned CNT_W_DEFAULT = 6;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN,
    MAIN_YELLOW,
    ALL_RED1,
    SIDE_GREEN,
    SIDE_YELLOW,
    ALL_RED2,
    WALK
  } phase_t;

endpackage

// File: rtl/ped_latch.sv
// Pedestrian request latch.
//   clk, reset : clock, asynchronous active-low reset
//   ped_req    : pedestrian button (level or pulse)
//   restart    : cycle-restart strobe from the sequencer
//   ped        : pedestrian phase included in the current cycle
// A request arriving on the restart edge is captured straight into ped and
// does not leave pending set, so it is not served twice.
module ped_latch (
  input  logic clk,
  input  logic reset,
  input  logic ped_req,
  input  logic restart,
  output logic ped
);

  logic pending;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= 1'b0;
      ped     <= 1'b0;
    end else if (restart) begin
      ped     <= pending | ped_req;
      pending <= 1'b0;
    end else if (ped_req) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Phase sequencer: steps the main/side signal heads through one cycle,
// owns the cycle counter and the latched PED flag.
//   clk, reset  : clock, asynchronous active-low reset
//   tick        : one-clk advance strobe; nothing moves without it
//   enable      : phase-advance request from the enable generator
//   ped_req     : pedestrian button
//   counter     : cycle position (cleared on entry to MAIN_GREEN)
//   PED         : pedestrian phase included in this cycle
//   main_light  : one-hot {R,Y,G}
//   side_light  : one-hot {R,Y,G}
//   walk        : walk lamp
//   fault       : sticky watchdog flag
module light_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             ped_req,
  output logic [CNT_W-1:0] counter,
  output logic             PED,
  output logic [2:0]       main_light,
  output logic [2:0]       side_light,
  output logic             walk,
  output logic             fault
);

  phase_t           phase, phase_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             fault_nxt;
  logic             restart;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase   <= MAIN_GREEN;
      counter <= '0;
      fault   <= 1'b0;
    end else begin
      phase   <= phase_nxt;
      counter <= cnt_nxt;
      fault   <= fault_nxt;
    end
  end

  // A normal advance at all-ones beats the watchdog; the counter then simply
  // wraps through the increment.
  always_comb begin
    phase_nxt = phase;
    cnt_nxt   = counter;
    fault_nxt = fault;
    restart   = 1'b0;
    if (tick) begin
      if (enable) begin
        unique case (phase)
          MAIN_GREEN:  phase_nxt = MAIN_YELLOW;
          MAIN_YELLOW: phase_nxt = ALL_RED1;
          ALL_RED1:    phase_nxt = SIDE_GREEN;
          SIDE_GREEN:  phase_nxt = SIDE_YELLOW;
          SIDE_YELLOW: phase_nxt = ALL_RED2;
          ALL_RED2:    phase_nxt = PED ? WALK : MAIN_GREEN;
          WALK:        phase_nxt = MAIN_GREEN;
          default:     phase_nxt = MAIN_GREEN;
        endcase
        if (phase_nxt == MAIN_GREEN) begin
          cnt_nxt = '0;
          restart = 1'b1;
        end else begin
          cnt_nxt = counter + 1'b1;
        end
      end else if (&counter) begin
        phase_nxt = MAIN_GREEN;
        cnt_nxt   = '0;
        fault_nxt = 1'b1;
        restart   = 1'b1;
      end else begin
        cnt_nxt = counter + 1'b1;
      end
    end
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk       = 1'b0;
    unique case (phase)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
      WALK:        walk       = 1'b1;
      default:     ;
    endcase
  end

  ped_latch u_ped (
    .clk     (clk),
    .reset   (reset),
    .ped_req (ped_req),
    .restart (restart),
    .ped     (PED)
  );

endmodule
